// File: rtl/latch_bank_sequencer.sv
// Round-robin sharer for one transparent-latch bank: grants a requester, drives its data,
// then sequences setup / enable / hold on the latch enable with fully registered outputs.
module latch_bank_sequencer #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [N_REQ-1:0]          req_in,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]         d_out,
  output logic                      en_out,
  output logic [N_REQ-1:0]          gnt_out,
  output logic [N_REQ-1:0]          done_out,
  output logic                      busy_out
);

  localparam int MAX_CYC = (SETUP_CYC > EN_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int GW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [GW-1:0]     last_gnt, last_gnt_n, win;
  logic              found;
  int                idx;
  logic [DATA_W-1:0] d_n;
  logic              en_n, busy_n;
  logic [N_REQ-1:0]  gnt_n, done_n;

  // First requesting index strictly after last_gnt, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_gnt) + 1 + k) % N_REQ;
      if (!found && req_in[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_gnt_n = last_gnt;
    d_n        = d_out;
    en_n       = en_out;
    gnt_n      = gnt_out;
    done_n     = '0;
    busy_n     = busy_out;
    case (state)
      IDLE: begin
        en_n   = 1'b0;
        gnt_n  = '0;
        busy_n = 1'b0;
        if (found) begin
          state_n    = SETUP;
          cnt_n      = CW'(SETUP_CYC - 1);
          gnt_n      = ONE << win;
          d_n        = data_in[int'(win)*DATA_W +: DATA_W];
          busy_n     = 1'b1;
          last_gnt_n = win;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = ENABLE;
          cnt_n   = CW'(EN_CYC - 1);
          en_n    = 1'b1;
        end else cnt_n = cnt - CW'(1);
      end
      ENABLE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CW'(HOLD_CYC - 1);
          en_n    = 1'b0;
        end else cnt_n = cnt - CW'(1);
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = gnt_out;
        end else cnt_n = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset drops en_out asynchronously, so an aborted transaction never leaves the latch open.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= GW'(N_REQ - 1);
      d_out    <= '0;
      en_out   <= 1'b0;
      gnt_out  <= '0;
      done_out <= '0;
      busy_out <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_gnt <= last_gnt_n;
      d_out    <= d_n;
      en_out   <= en_n;
      gnt_out  <= gnt_n;
      done_out <= done_n;
      busy_out <= busy_n;
    end
  end

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed bench for latch_bank_sequencer at default parameters (4 req, 8 bit, 1/2/1).
module tb_latch_bank_sequencer;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [3:0]  req_in;
  logic [31:0] data_in;
  logic [7:0]  d_out;
  logic        en_out;
  logic [3:0]  gnt_out;
  logic [3:0]  done_out;
  logic        busy_out;

  int n_chk  = 0;
  int n_pass = 0;

  latch_bank_sequencer dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .req_in   (req_in),
    .data_in  (data_in),
    .d_out    (d_out),
    .en_out   (en_out),
    .gnt_out  (gnt_out),
    .done_out (done_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #3;
    rst_n_in = 1'b1;
    step();
  endtask

  int en_cnt;

  initial begin
    // 1. reset values
    rst_n_in = 1'b0;
    req_in   = 4'($urandom);
    data_in  = $urandom;
    #1;
    chk("rst_en",   {31'b0, en_out},   32'd0);
    chk("rst_gnt",  {28'b0, gnt_out},  32'd0);
    chk("rst_done", {28'b0, done_out}, 32'd0);
    chk("rst_busy", {31'b0, busy_out}, 32'd0);
    chk("rst_d",    {24'b0, d_out},    32'd0);
    req_in = 4'b0000;
    step();
    rst_n_in = 1'b1;
    step(); step();
    chk("rel_gnt",  {28'b0, gnt_out},  32'd0);
    chk("rel_busy", {31'b0, busy_out}, 32'd0);
    chk("rel_en",   {31'b0, en_out},   32'd0);

    // 2. single request from requester 2
    req_in  = 4'b0100;
    data_in = {8'h3C, 8'hA5, 8'h77, 8'h01};
    step();                                   // E0
    req_in  = 4'b0000;
    data_in = 32'hFFFF_FFFF;                  // must not leak into d_out
    chk("s_gnt",  {28'b0, gnt_out},  32'h4);
    chk("s_d",    {24'b0, d_out},    32'hA5);
    chk("s_busy", {31'b0, busy_out}, 32'd1);
    chk("s_en0",  {31'b0, en_out},   32'd0);
    step(); chk("s_en1", {31'b0, en_out}, 32'd1);
    step(); chk("s_en2", {31'b0, en_out}, 32'd1);
    step(); chk("s_en3", {31'b0, en_out}, 32'd0);
    chk("s_d3",   {24'b0, d_out},    32'hA5);
    chk("s_gnt3", {28'b0, gnt_out},  32'h4);
    step();                                   // E0+4
    chk("s_done",  {28'b0, done_out}, 32'h4);
    chk("s_gnt4",  {28'b0, gnt_out},  32'd0);
    chk("s_busy4", {31'b0, busy_out}, 32'd0);
    step(); chk("s_done5", {28'b0, done_out}, 32'd0);

    // 4. priority after grant to 2: 3 before 1
    req_in  = 4'b1010;
    data_in = {8'hD3, 8'h00, 8'hB1, 8'h00};
    step();
    chk("p_gnt3", {28'b0, gnt_out}, 32'h8);
    chk("p_d3",   {24'b0, d_out},   32'hD3);
    repeat (5) step();
    chk("p_gnt1", {28'b0, gnt_out}, 32'h2);
    chk("p_d1",   {24'b0, d_out},   32'hB1);
    req_in = 4'b0000;
    repeat (4) step();
    chk("p_done1", {28'b0, done_out}, 32'h2);

    // 3. full rotation from reset
    do_reset();
    req_in  = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) begin
      logic [3:0] eg;
      logic [7:0] ed;
      eg = 4'b0001 << (i % 4);
      ed = 8'h11 * 8'((i % 4) + 1);
      step();
      chk("r_gnt", {28'b0, gnt_out}, {28'b0, eg});
      chk("r_d",   {24'b0, d_out},   {24'b0, ed});
      en_cnt = 0;
      for (int j = 1; j < 5; j++) begin
        step();
        en_cnt += int'(en_out);
      end
      chk("r_en_cnt", en_cnt, 32'd2);
    end
    req_in = 4'b0000;
    step();
    chk("r_idle", {31'b0, busy_out}, 32'd0);

    // 5. request dropped during SETUP (last grant was 0, so 1 wins)
    req_in  = 4'b0010;
    data_in = {8'h00, 8'h00, 8'h5A, 8'h00};
    step();
    chk("d_gnt", {28'b0, gnt_out}, 32'h2);
    req_in  = 4'b0000;
    step(); chk("d_en1", {31'b0, en_out}, 32'd1);
    step(); step();
    chk("d_d3",   {24'b0, d_out},   32'h5A);
    chk("d_gnt3", {28'b0, gnt_out}, 32'h2);
    step();
    chk("d_done", {28'b0, done_out}, 32'h2);

    // 6. reset in ENABLE
    step();
    req_in  = 4'b0100;
    step();
    req_in  = 4'b0000;
    step();
    chk("x_en_pre", {31'b0, en_out}, 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("x_en",   {31'b0, en_out},   32'd0);
    chk("x_gnt",  {28'b0, gnt_out},  32'd0);
    chk("x_busy", {31'b0, busy_out}, 32'd0);
    step();
    chk("x_done_rst", {28'b0, done_out}, 32'd0);
    rst_n_in = 1'b1;
    req_in   = 4'b1001;
    data_in  = {8'h99, 8'h00, 8'h00, 8'h10};
    step();
    chk("x_gnt0", {28'b0, gnt_out}, 32'h1);
    chk("x_d0",   {24'b0, d_out},   32'h10);
    req_in = 4'b0000;
    step(); step(); step();
    chk("x_done_no", {28'b0, done_out}, 32'd0);
    step();
    chk("x_done0", {28'b0, done_out}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
